// File: rtl/exu_gpr_file.sv
// GPR file (x1..x31, x0 reads zero) shared by the execute handlers through a one-hot select.
// Two combinational read ports with optional write forwarding, one write per clock.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif

module exu_gpr_file #(
  parameter int NUM_MST = 4,
  parameter int BYPASS  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_MST-1:0]             sel,
  input  logic [NUM_MST*`RV_GPR_AW-1:0]  mst_ra1,
  input  logic [NUM_MST*`RV_GPR_AW-1:0]  mst_ra2,
  input  logic [NUM_MST-1:0]             mst_wen,
  input  logic [NUM_MST*`RV_GPR_AW-1:0]  mst_wa,
  input  logic [NUM_MST*`RV_XLEN-1:0]    mst_wd,
  output logic [`RV_XLEN-1:0]            rd1,
  output logic [`RV_XLEN-1:0]            rd2,
  output logic                           sel_err,
  input  logic                           err_clr,
  output logic [31:0]                    wr_cnt
);
  localparam int AW = `RV_GPR_AW;
  localparam int XW = `RV_XLEN;

  logic [XW-1:0] r_gpr [1:31];
  logic          r_sel_err;
  logic [31:0]   r_wr_cnt;

  logic          w_multi, w_legal, w_wen, w_wr;
  logic [AW-1:0] w_ra1, w_ra2, w_wa;
  logic [XW-1:0] w_wd, w_rd1, w_rd2;

  // clearing the lowest set bit leaves something only when two or more bits are set
  assign w_multi = |(sel & (sel - 1'b1));
  assign w_legal = (|sel) && !w_multi;

  always_comb begin
    w_ra1 = '0;
    w_ra2 = '0;
    w_wen = 1'b0;
    w_wa  = '0;
    w_wd  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_legal && sel[i]) begin
        w_ra1 = mst_ra1[i*AW +: AW];
        w_ra2 = mst_ra2[i*AW +: AW];
        w_wen = mst_wen[i];
        w_wa  = mst_wa[i*AW +: AW];
        w_wd  = mst_wd[i*XW +: XW];
      end
    end
  end

  assign w_wr = w_legal && w_wen && (w_wa != '0);

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_legal) begin
      if (w_ra1 != '0) w_rd1 = r_gpr[w_ra1];
      if (w_ra2 != '0) w_rd2 = r_gpr[w_ra2];
      if (BYPASS != 0 && w_wr && w_wa == w_ra1) w_rd1 = w_wd;
      if (BYPASS != 0 && w_wr && w_wa == w_ra2) w_rd2 = w_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) r_gpr[r] <= '0;
      r_wr_cnt  <= '0;
      r_sel_err <= 1'b0;
    end else begin
      if (w_wr) begin
        r_gpr[w_wa] <= w_wd;
        r_wr_cnt    <= r_wr_cnt + 32'd1;
      end
      // a new illegal cycle outranks a simultaneous clear
      if (w_multi)      r_sel_err <= 1'b1;
      else if (err_clr) r_sel_err <= 1'b0;
    end
  end

  assign rd1     = w_rd1;
  assign rd2     = w_rd2;
  assign sel_err = r_sel_err;
  assign wr_cnt  = r_wr_cnt;
endmodule

// File: tb/tb_exu_gpr_file.sv
// Directed bench for exu_gpr_file: one forwarding and one non-forwarding instance on shared stimulus.
module tb_exu_gpr_file;
  localparam int NM = 4;
  localparam int AW = 5;
  localparam int XW = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NM-1:0]      sel;
  logic [NM*AW-1:0]   mst_ra1, mst_ra2, mst_wa;
  logic [NM-1:0]      mst_wen;
  logic [NM*XW-1:0]   mst_wd;
  logic               err_clr;
  logic [XW-1:0]      rd1, rd2, rd1_nb, rd2_nb;
  logic               sel_err, sel_err_nb;
  logic [31:0]        wr_cnt, wr_cnt_nb;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  exu_gpr_file #(.NUM_MST(NM), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .mst_ra1(mst_ra1), .mst_ra2(mst_ra2),
    .mst_wen(mst_wen), .mst_wa(mst_wa), .mst_wd(mst_wd), .rd1(rd1), .rd2(rd2),
    .sel_err(sel_err), .err_clr(err_clr), .wr_cnt(wr_cnt));

  exu_gpr_file #(.NUM_MST(NM), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .sel(sel), .mst_ra1(mst_ra1), .mst_ra2(mst_ra2),
    .mst_wen(mst_wen), .mst_wa(mst_wa), .mst_wd(mst_wd), .rd1(rd1_nb), .rd2(rd2_nb),
    .sel_err(sel_err_nb), .err_clr(err_clr), .wr_cnt(wr_cnt_nb));

  task automatic clr_in();
    sel = '0; mst_ra1 = '0; mst_ra2 = '0; mst_wa = '0; mst_wen = '0; mst_wd = '0; err_clr = 1'b0;
  endtask

  task automatic drv(input int m, input logic [4:0] ra1, input logic [4:0] ra2,
                     input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    mst_ra1[m*AW +: AW] = ra1;
    mst_ra2[m*AW +: AW] = ra2;
    mst_wen[m]          = wen;
    mst_wa[m*AW +: AW]  = wa;
    mst_wd[m*XW +: XW]  = wd;
  endtask

  // inputs change on the falling edge; the rising edge in between commits
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    sel = 4'b0001;
    for (int a = 0; a < 32; a++) begin
      drv(0, a[4:0], 5'(31 - a), 1'b0, 5'd0, 32'd0);
      #1;
      n_chk++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0)
        $display("FAIL reset_read a=%0d rd1=%h rd2=%h want 0", a, rd1, rd2);
      else n_pass++;
    end
    n_chk++;
    if (wr_cnt !== 32'd0 || sel_err !== 1'b0)
      $display("FAIL reset_state wr_cnt=%0d sel_err=%b want 0/0", wr_cnt, sel_err);
    else n_pass++;
  endtask

  task automatic test_write_readback();
    clr_in();
    sel = 4'b0100;
    drv(2, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cyc();
    clr_in();
    sel = 4'b0001;
    drv(0, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk++;
    if (rd1 !== 32'hDEAD_BEEF) $display("FAIL readback rd1=%h want deadbeef", rd1);
    else n_pass++;
    n_chk++;
    if (wr_cnt !== 32'd1) $display("FAIL wr_cnt_1 got=%0d want 1", wr_cnt);
    else n_pass++;
    drv(0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234);
    #1;
    n_chk++;
    if (rd1 !== 32'd0) $display("FAIL x0_fwd rd1=%h want 0", rd1);
    else n_pass++;
    cyc();
    drv(0, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk++;
    if (rd1 !== 32'd0 || rd2 !== 32'hDEAD_BEEF)
      $display("FAIL x0_write rd1=%h rd2=%h want 0/deadbeef", rd1, rd2);
    else n_pass++;
    n_chk++;
    if (wr_cnt !== 32'd1) $display("FAIL x0_nocount got=%0d want 1", wr_cnt);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    clr_in();
    sel = 4'b0001;
    drv(0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1);
    cyc();
    drv(0, 5'd7, 5'd7, 1'b1, 5'd7, 32'h2);
    #1;
    n_chk++;
    if (rd1 !== 32'h2 || rd2 !== 32'h2) $display("FAIL fwd_bypass rd1=%h rd2=%h want 2/2", rd1, rd2);
    else n_pass++;
    n_chk++;
    if (rd1_nb !== 32'h1 || rd2_nb !== 32'h1)
      $display("FAIL fwd_nobypass rd1=%h rd2=%h want 1/1", rd1_nb, rd2_nb);
    else n_pass++;
    cyc();
    drv(0, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk++;
    if (rd1_nb !== 32'h2 || rd2_nb !== 32'h2)
      $display("FAIL fwd_nobypass_next rd1=%h rd2=%h want 2/2", rd1_nb, rd2_nb);
    else n_pass++;
    n_chk++;
    if (wr_cnt !== 32'd3 || wr_cnt_nb !== 32'd3)
      $display("FAIL fwd_cnt got=%0d/%0d want 3/3", wr_cnt, wr_cnt_nb);
    else n_pass++;
  endtask

  task automatic test_ignored_master();
    clr_in();
    sel = 4'b0001;
    drv(0, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0);
    drv(3, 5'd7, 5'd7, 1'b1, 5'd9, 32'hFF);
    #1;
    n_chk++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL ignored_addr rd1=%h rd2=%h want 0/0", rd1, rd2);
    else n_pass++;
    cyc();
    #1;
    n_chk++;
    if (rd1 !== 32'd0 || wr_cnt !== 32'd3)
      $display("FAIL ignored_wen x9=%h wr_cnt=%0d want 0/3", rd1, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal_sel();
    clr_in();
    sel = 4'b0011;
    drv(0, 5'd7, 5'd3, 1'b1, 5'd3, 32'hAA);
    drv(1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL illegal_rd rd1=%h rd2=%h want 0/0", rd1, rd2);
    else n_pass++;
    n_chk++;
    if (sel_err !== 1'b0) $display("FAIL illegal_early sel_err=%b want 0", sel_err);
    else n_pass++;
    cyc();
    clr_in();
    sel = 4'b0001;
    drv(0, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk++;
    if (rd1 !== 32'd0 || wr_cnt !== 32'd3 || sel_err !== 1'b1)
      $display("FAIL illegal_effect x3=%h wr_cnt=%0d sel_err=%b want 0/3/1", rd1, wr_cnt, sel_err);
    else n_pass++;
    sel = 4'b0011;
    err_clr = 1'b1;
    cyc();
    #1;
    n_chk++;
    if (sel_err !== 1'b1) $display("FAIL set_wins sel_err=%b want 1", sel_err);
    else n_pass++;
    sel = 4'b0001;
    cyc();
    #1;
    n_chk++;
    if (sel_err !== 1'b0) $display("FAIL err_clr sel_err=%b want 0", sel_err);
    else n_pass++;
    err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    clr_in();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sel = 4'b0001;
    for (int r = 1; r < 32; r++) begin
      drv(0, 5'd0, 5'd0, 1'b1, r[4:0], 32'h0101_0101 * r);
      cyc();
    end
    drv(0, 5'd10, 5'd20, 1'b0, 5'd0, 32'd0);
    #1;
    n_chk++;
    if (rd1 !== 32'h0A0A_0A0A || rd2 !== 32'h1414_1414 || wr_cnt !== 32'd31)
      $display("FAIL preload rd1=%h rd2=%h wr_cnt=%0d want 0a0a0a0a/14141414/31", rd1, rd2, wr_cnt);
    else n_pass++;
    drv(1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    sel = 4'b0001;
    drv(0, 5'd10, 5'd20, 1'b1, 5'd4, 32'hBAD);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || wr_cnt !== 32'd0)
      $display("FAIL async_rst rd1=%h rd2=%h wr_cnt=%0d want 0/0/0", rd1, rd2, wr_cnt);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    drv(0, 5'd4, 5'd31, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || wr_cnt !== 32'd0)
      $display("FAIL rst_lost_write x4=%h x31=%h wr_cnt=%0d want 0/0/0", rd1, rd2, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    clr_in();
    sel = 4'b0001;
    force dut.r_wr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_wr_cnt;
    #1;
    n_chk++;
    if (wr_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_preset got=%h want ffffffff", wr_cnt);
    else n_pass++;
    drv(0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h55);
    cyc();
    #1;
    n_chk++;
    if (wr_cnt !== 32'd0) $display("FAIL wrap got=%h want 0", wr_cnt);
    else n_pass++;
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    test_reset();
    test_write_readback();
    test_forwarding();
    test_ignored_master();
    test_illegal_sel();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
